// File: rtl/exe_mem_stage_reg_pkg.sv
// Shared types for the EX->MEM stage register: occupancy states, default-width payload
// and the forwarding qualifier used by the bypass network.
package exe_mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } state_e;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_read;
    logic                  mem_write;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] st_val;
    logic [DEF_REG_AW-1:0] dest;
  } payload_t;

  // A load result is not known until MEM completes, so only ALU results may be bypassed.
  function automatic logic fwd_ok(input logic valid, input logic wb_en, input logic mem_read);
    return valid & wb_en & ~mem_read;
  endfunction

endpackage

// File: rtl/exe_mem_stage_reg_if.sv
// Upstream/downstream handshake and payload bundle of the EX->MEM stage register.
// The stage register itself uses the slave view; the surrounding pipeline drives the master view.
interface exe_mem_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic              in_mem_read;
  logic              in_mem_write;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_st_val;
  logic [REG_AW-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic              wb_en;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] st_val;
  logic [REG_AW-1:0] dest;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_dest;
  logic [DATA_W-1:0] fwd_value;

  modport master (
    output flush, in_valid, in_wb_en, in_mem_read, in_mem_write,
           in_alu_result, in_st_val, in_dest, out_ready,
    input  in_ready, out_valid, wb_en, mem_read, mem_write,
           alu_result, st_val, dest, fwd_valid, fwd_dest, fwd_value
  );

  modport slave (
    input  flush, in_valid, in_wb_en, in_mem_read, in_mem_write,
           in_alu_result, in_st_val, in_dest, out_ready,
    output in_ready, out_valid, wb_en, mem_read, mem_write,
           alu_result, st_val, dest, fwd_valid, fwd_dest, fwd_value
  );
endinterface

// File: rtl/exe_mem_slot.sv
// One payload entry of the stage register: clears on reset, otherwise loads only when enabled
// so the data flops stay quiet while the pipeline is stalled.
module exe_mem_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: non-blocking (<=) so every flop samples pre-edge values; blocking here would make
  // results depend on the order in which simulators evaluate the always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EX->MEM pipeline register with valid/ready flow control, optional skid entry,
// synchronous flush and a forwarding tap taken from the main entry.
module exe_mem_stage_reg
  import exe_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int SKID   = 1
) (
  input logic clk,
  input logic rst,
  exe_mem_stage_reg_if.slave bus
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_val;
    logic [REG_AW-1:0] dest;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  state_e state_q;
  logic   out_valid_q;
  logic   in_ready_q;
  logic   in_fire;
  logic   out_fire;
  logic   main_load;
  slot_t  in_payload;
  slot_t  main_d;
  slot_t  main_q;
  slot_t  skid_q;

  // With the skid entry, in_ready comes straight from a flop so out_ready never reaches it.
  assign bus.in_ready = (SKID != 0) ? in_ready_q : (~out_valid_q | bus.out_ready);
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = out_valid_q & bus.out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_payload            = '0;
    in_payload.wb_en      = bus.in_wb_en;
    in_payload.mem_read   = bus.in_mem_read;
    in_payload.mem_write  = bus.in_mem_write;
    in_payload.alu_result = bus.in_alu_result;
    in_payload.st_val     = bus.in_st_val;
    in_payload.dest       = bus.in_dest;
    main_d                = (state_q == SKIDDED) ? skid_q : in_payload;
    main_load             = ~bus.flush &
                            ((in_fire & ((state_q == EMPTY) | ((state_q == FULL) & out_fire))) |
                             ((state_q == SKIDDED) & out_fire));
  end

  exe_mem_slot #(.W(SLOT_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      // Skid captures the entry that arrives while main is blocked; it is younger than main.
      assign skid_load = ~bus.flush & in_fire & (state_q == FULL) & ~bus.out_ready;
      exe_mem_slot #(.W(SLOT_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_payload),
        .q    (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (bus.flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_q     <= FULL;
          out_valid_q <= 1'b1;
        end
        FULL: begin
          if ((SKID != 0) && in_fire && !bus.out_ready) begin
            state_q    <= SKIDDED;
            in_ready_q <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        SKIDDED: if (bus.out_ready) begin
          state_q    <= FULL;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Bubbles must not look like writes or bypass sources downstream.
  assign bus.out_valid  = out_valid_q;
  assign bus.wb_en      = out_valid_q & main_q.wb_en;
  assign bus.mem_read   = out_valid_q & main_q.mem_read;
  assign bus.mem_write  = out_valid_q & main_q.mem_write;
  assign bus.alu_result = main_q.alu_result;
  assign bus.st_val     = main_q.st_val;
  assign bus.dest       = main_q.dest;
  assign bus.fwd_valid  = fwd_ok(out_valid_q, main_q.wb_en, main_q.mem_read);
  assign bus.fwd_dest   = main_q.dest;
  assign bus.fwd_value  = main_q.alu_result;

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Directed bench: vector table on the skid instance, plus hand sequences for async reset
// and for the single-entry (combinational in_ready) instance.
module tb_exe_mem_stage_reg;
  import exe_mem_pkg::*;

  localparam logic [31:0] ST_MASK = 32'hFFFF_0000;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  exe_mem_stage_reg_if #(.DATA_W(32), .REG_AW(4)) bus0 ();
  exe_mem_stage_reg_if #(.DATA_W(16), .REG_AW(5)) bus1 ();

  exe_mem_stage_reg #(.DATA_W(32), .REG_AW(4), .SKID(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  exe_mem_stage_reg #(.DATA_W(16), .REG_AW(5), .SKID(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv, ordy, fl;
    payload_t    p;
    logic        ov, ir, wb, mr, mw, fv;
    logic [3:0]  dest;
    logic [31:0] alu;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t v(input logic iv, input logic ordy, input logic fl,
                             input logic wb, input logic mr, input logic mw,
                             input logic [3:0] d, input logic [31:0] a,
                             input logic ov, input logic ir, input logic ewb, input logic emr,
                             input logic emw, input logic efv,
                             input logic [3:0] ed, input logic [31:0] ea);
    vec_t r;
    r.iv = iv; r.ordy = ordy; r.fl = fl;
    r.p.wb_en = wb; r.p.mem_read = mr; r.p.mem_write = mw;
    r.p.dest = d; r.p.alu_result = a; r.p.st_val = a ^ ST_MASK;
    r.ov = ov; r.ir = ir; r.wb = ewb; r.mr = emr; r.mw = emw; r.fv = efv;
    r.dest = ed; r.alu = ea;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input vec_t t);
    bus0.in_valid      = t.iv;
    bus0.out_ready     = t.ordy;
    bus0.flush         = t.fl;
    bus0.in_wb_en      = t.p.wb_en;
    bus0.in_mem_read   = t.p.mem_read;
    bus0.in_mem_write  = t.p.mem_write;
    bus0.in_dest       = t.p.dest;
    bus0.in_alu_result = t.p.alu_result;
    bus0.in_st_val     = t.p.st_val;
  endtask

  initial begin
    //          iv or fl wb mr mw  d      a       | ov ir wb mr mw fv  d      a
    vecs[0]  = v(1, 1, 0, 1, 0, 0, 4'd1, 32'h11,    1, 1, 1, 0, 0, 1, 4'd1, 32'h11);
    vecs[1]  = v(1, 1, 0, 1, 1, 0, 4'd2, 32'h22,    1, 1, 1, 1, 0, 0, 4'd2, 32'h22);
    vecs[2]  = v(1, 1, 0, 0, 0, 1, 4'd3, 32'h33,    1, 1, 0, 0, 1, 0, 4'd3, 32'h33);
    vecs[3]  = v(0, 1, 0, 1, 0, 0, 4'd9, 32'h99,    0, 1, 0, 0, 0, 0, 4'd3, 32'h33);
    vecs[4]  = v(1, 0, 0, 1, 0, 0, 4'd4, 32'hA,     1, 1, 1, 0, 0, 1, 4'd4, 32'hA);
    vecs[5]  = v(1, 0, 0, 0, 0, 1, 4'd6, 32'hB,     1, 0, 1, 0, 0, 1, 4'd4, 32'hA);
    vecs[6]  = v(1, 0, 0, 1, 1, 0, 4'd7, 32'hC,     1, 0, 1, 0, 0, 1, 4'd4, 32'hA);
    vecs[7]  = v(0, 1, 0, 0, 0, 0, 4'd0, 32'h0,     1, 1, 0, 0, 1, 0, 4'd6, 32'hB);
    vecs[8]  = v(0, 1, 0, 0, 0, 0, 4'd0, 32'h0,     0, 1, 0, 0, 0, 0, 4'd6, 32'hB);
    vecs[9]  = v(1, 0, 0, 1, 0, 0, 4'd8, 32'h1,     1, 1, 1, 0, 0, 1, 4'd8, 32'h1);
    vecs[10] = v(1, 0, 0, 1, 0, 0, 4'd9, 32'h2,     1, 0, 1, 0, 0, 1, 4'd8, 32'h1);
    vecs[11] = v(1, 0, 1, 1, 0, 0, 4'd10, 32'h3,    0, 1, 0, 0, 0, 0, 4'd8, 32'h1);
    vecs[12] = v(0, 1, 0, 0, 0, 0, 4'd0, 32'h0,     0, 1, 0, 0, 0, 0, 4'd8, 32'h1);
    vecs[13] = v(1, 1, 0, 1, 0, 0, 4'd5, 32'hDEAD,  1, 1, 1, 0, 0, 1, 4'd5, 32'hDEAD);
    vecs[14] = v(1, 1, 0, 1, 1, 0, 4'd5, 32'hBEEF,  1, 1, 1, 1, 0, 0, 4'd5, 32'hBEEF);
    vecs[15] = v(0, 0, 0, 0, 0, 0, 4'd0, 32'h0,     1, 1, 1, 1, 0, 0, 4'd5, 32'hBEEF);
    vecs[16] = v(1, 1, 1, 1, 0, 0, 4'd12, 32'h77,   0, 1, 0, 0, 0, 0, 4'd5, 32'hBEEF);

    rst = 1'b1;
    drive0(v(0, 0, 0, 0, 0, 0, 4'd0, 32'h0, 0, 0, 0, 0, 0, 0, 4'd0, 32'h0));
    bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.in_wb_en = 1'b0; bus1.in_mem_read = 1'b0; bus1.in_mem_write = 1'b0;
    bus1.in_alu_result = '0; bus1.in_st_val = '0; bus1.in_dest = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst out_valid", bus0.out_valid, 0);
    check("rst in_ready", bus0.in_ready, 1);
    check("rst alu_result", bus0.alu_result, 0);
    check("rst st_val", bus0.st_val, 0);
    check("rst dest", bus0.dest, 0);
    check("rst fwd_valid", bus0.fwd_valid, 0);
    check("rst s0 out_valid", bus1.out_valid, 0);
    check("rst s0 in_ready", bus1.in_ready, 1);

    for (int i = 0; i < 17; i++) begin
      drive0(vecs[i]);
      tick();
      check($sformatf("v%0d out_valid", i), bus0.out_valid, vecs[i].ov);
      check($sformatf("v%0d in_ready", i), bus0.in_ready, vecs[i].ir);
      check($sformatf("v%0d wb_en", i), bus0.wb_en, vecs[i].wb);
      check($sformatf("v%0d mem_read", i), bus0.mem_read, vecs[i].mr);
      check($sformatf("v%0d mem_write", i), bus0.mem_write, vecs[i].mw);
      check($sformatf("v%0d fwd_valid", i), bus0.fwd_valid, vecs[i].fv);
      check($sformatf("v%0d dest", i), bus0.dest, vecs[i].dest);
      check($sformatf("v%0d fwd_dest", i), bus0.fwd_dest, vecs[i].dest);
      check($sformatf("v%0d alu_result", i), bus0.alu_result, vecs[i].alu);
      check($sformatf("v%0d fwd_value", i), bus0.fwd_value, vecs[i].alu);
      check($sformatf("v%0d st_val", i), bus0.st_val, vecs[i].alu ^ ST_MASK);
    end

    // Async reset while FULL: outputs clear before any clock edge.
    drive0(v(1, 0, 0, 1, 0, 0, 4'd3, 32'h55, 0, 0, 0, 0, 0, 0, 4'd0, 32'h0));
    tick();
    bus0.in_valid = 1'b0;
    check("ar full out_valid", bus0.out_valid, 1);
    check("ar full alu_result", bus0.alu_result, 32'h55);
    #2 rst = 1'b1;
    #1;
    check("ar out_valid", bus0.out_valid, 0);
    check("ar alu_result", bus0.alu_result, 0);
    check("ar dest", bus0.dest, 0);
    check("ar wb_en", bus0.wb_en, 0);
    check("ar fwd_valid", bus0.fwd_valid, 0);
    check("ar in_ready", bus0.in_ready, 1);
    #1 rst = 1'b0;
    tick();
    check("ar post out_valid", bus0.out_valid, 0);
    check("ar post in_ready", bus0.in_ready, 1);

    // Async reset while SKIDDED discards both entries.
    drive0(v(1, 0, 0, 1, 0, 0, 4'd1, 32'h66, 0, 0, 0, 0, 0, 0, 4'd0, 32'h0));
    tick();
    bus0.in_alu_result = 32'h77;
    tick();
    check("rs skidded in_ready", bus0.in_ready, 0);
    bus0.in_valid = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    check("rs drain1 out_valid", bus0.out_valid, 0);
    tick();
    check("rs drain2 out_valid", bus0.out_valid, 0);
    check("rs drain2 in_ready", bus0.in_ready, 1);

    // Single-entry instance: in_ready follows out_ready combinationally while FULL.
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b0; bus1.in_wb_en = 1'b1;
    bus1.in_alu_result = 16'h1234; bus1.in_dest = 5'h1F;
    #1;
    check("s0 empty in_ready", bus1.in_ready, 1);
    tick();
    check("s0 load out_valid", bus1.out_valid, 1);
    check("s0 load alu_result", bus1.alu_result, 16'h1234);
    check("s0 load dest", bus1.dest, 5'h1F);
    check("s0 stall in_ready", bus1.in_ready, 0);
    bus1.in_alu_result = 16'h5678; bus1.in_dest = 5'h02;
    bus1.out_ready = 1'b1;
    #1;
    check("s0 release in_ready", bus1.in_ready, 1);
    tick();
    check("s0 replace out_valid", bus1.out_valid, 1);
    check("s0 replace alu_result", bus1.alu_result, 16'h5678);
    check("s0 replace dest", bus1.dest, 5'h02);
    bus1.out_ready = 1'b0; bus1.in_alu_result = 16'h9999;
    #1;
    check("s0 stall2 in_ready", bus1.in_ready, 0);
    tick();
    check("s0 hold alu_result", bus1.alu_result, 16'h5678);
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    tick();
    check("s0 drain out_valid", bus1.out_valid, 0);
    check("s0 drain wb_en", bus1.wb_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage_reg.md
# exe_mem_stage_reg

Parametrised EX→MEM pipeline register with valid/ready flow control, an optional skid entry, synchronous flush and a forwarding tap. It carries the write-back/memory control bits, ALU result, store value and destination register from the execute stage to the memory stage. It supports back-pressure from a multi-cycle memory, so the stage can stall without a combinational ready path when `SKID=1`.

## Interface
- `DATA_W`, 32, width of `alu_result` and `st_val`
- `REG_AW`, 4, width of destination register index
- `SKID`, 1, 1 = two-entry (main + skid) with registered `in_ready`; 0 = single entry with combinational `in_ready`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous discard of all held and incoming entries
- `in_valid`  in  1  upstream entry present
- `in_ready`  out  1  block can accept this cycle
- `in_wb_en`, `in_mem_read`, `in_mem_write`  in  1 each  control bits
- `in_alu_result`, `in_st_val`  in  DATA_W  data
- `in_dest`  in  REG_AW  destination register
- `out_valid`  out  1  main entry valid
- `out_ready`  in  1  memory stage consumes main entry
- `wb_en`, `mem_read`, `mem_write`  out  1 each  gated by `out_valid`
- `alu_result`, `st_val`  out  DATA_W  main entry data
- `dest`  out  REG_AW  main entry destination
- `fwd_valid`  out  1  `out_valid & wb_en & ~mem_read`
- `fwd_dest`  out  REG_AW  equals `dest`
- `fwd_value`  out  DATA_W  equals `alu_result`

## Operation
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- States: EMPTY, FULL (main only), SKIDDED (main + skid; only when `SKID=1`).
- EMPTY: `in_fire` → FULL, payload loaded into main.
- FULL: `in_fire & out_fire` → FULL, main replaced. `in_fire & ~out_ready` → SKIDDED, payload into skid. `~in_fire & out_fire` → EMPTY. Otherwise hold.
- SKIDDED: `out_ready` → FULL, skid copied to main. Otherwise hold. No input is accepted.
- `in_ready`:
  - `SKID=1`: registered, `state != SKIDDED`.
  - `SKID=0`: `~out_valid | out_ready`, and FULL+`in_fire` always replaces main.
- `flush`: next state EMPTY regardless of other inputs. An entry firing in the same cycle is dropped. Data registers keep their values; only valid/state clears. `flush` dominates `in_fire` and `out_fire`. `out_fire` in the flush cycle still counts as consumed by downstream.
- Bubble gating: when `out_valid=0`, `wb_en`, `mem_read`, `mem_write` and `fwd_valid` read 0. Data outputs show stale values.
- Data registers load only on the relevant fire (no toggling while stalled).

## Timing
- Latency: accepted entry appears on outputs one cycle after `in_fire` when EMPTY, or FULL with `out_fire`.
- Throughput: one entry per cycle with `out_ready` held high, in both `SKID` modes.
- `SKID=1`: no combinational path from `out_ready` to `in_ready`.
- Reset (async assert, sync release at next edge):
  - state EMPTY; `out_valid=0`; all control, data and `dest` registers 0; `fwd_valid=0`.
  - `in_ready=1` after reset (0 only while SKIDDED).
- Reset mid-stall discards both entries immediately.
- Order preserved: skid entry is always older-than-incoming and younger than main.

## Structure
- Shared package `exe_mem_pkg`:
  - state enum (EMPTY/FULL/SKIDDED);
  - payload struct `{wb_en, mem_read, mem_write, alu_result[DATA_W], st_val[DATA_W], dest[REG_AW]}`, widths via package parameters matching defaults.
- Sub-module `exe_mem_slot`: payload register with async reset to zero and load enable. Instantiated for main and for skid (skid under `generate if (SKID)`).
- State machine and flow control in the top module.

## Test plan
- Reset then streaming: `out_ready=1`, inputs alu_result 0x11,0x22,0x33 on consecutive cycles → outputs 0x11,0x22,0x33 one cycle later each; `in_ready` stays 1.
- Back-pressure, `SKID=1`: hold `out_ready=0` after 0xA accepted, present 0xB → state SKIDDED, `in_ready=0`, output 0xA held. Release `out_ready` → 0xA consumed, then 0xB, no loss or duplication.
- Flush in SKIDDED with `in_valid=1` → next cycle `out_valid=0`, `wb_en=0`, `in_ready=1`; none of the three entries ever emitted afterwards.
- Forwarding: entry `wb_en=1, mem_read=0, dest=5, alu_result=0xDEAD` → `fwd_valid=1, fwd_dest=5, fwd_value=0xDEAD`. Same with `mem_read=1` → `fwd_valid=0`.
- `SKID=0`, `DATA_W=16`, `REG_AW=5`: `out_ready=0` while FULL → `in_ready=0` same cycle. Raise `out_ready` → `in_ready=1` same cycle, replacement accepted.
- Async `rst` pulse mid-cycle while FULL → outputs zero immediately without a clock edge; `in_ready=1` afterwards.
